// File: rtl/cxd_serial_ctrl_pkg.sv
// cxd_pkg: shared constants and width helpers for the CXD serial command port.
package cxd_pkg;

    localparam int unsigned CXD_BYTE_BITS = 8;
    localparam int unsigned CXD_CMD_BITS  = 24;
    localparam int unsigned CXD_ADDR_BITS = 4;

    // Width of cmd_len: enough to hold CMD_BITS/8 byte counts.
    function automatic int unsigned cxd_len_width(input int unsigned cmd_bits);
        return $clog2(cmd_bits / CXD_BYTE_BITS) + 1;
    endfunction

    // Width of the bit counter: must reach the CMD_BITS+1 overflow marker.
    function automatic int unsigned cxd_cnt_width(input int unsigned cmd_bits);
        return $clog2(cmd_bits + 2);
    endfunction

endpackage

// File: rtl/cxd_serial_ctrl_edge_sync.sv
// cxd_edge_sync: samples one asynchronous serial input into the sclk domain
// and flags rising/falling edges against the previous sample.
// Define CXD_SERIAL_SYNC_EN to add a 2-flop synchronizer ahead of the sample flop.
module cxd_edge_sync (
    input  logic sclk,
    input  logic rst_n,
    input  logic din,
    output logic lvl,
    output logic rise,
    output logic fall
);

`ifdef CXD_SERIAL_SYNC_EN
    localparam int unsigned STAGES = 3;
`else
    localparam int unsigned STAGES = 1;
`endif

    logic [STAGES-1:0] pipe;
    logic [STAGES-1:0] pipe_vld;
    logic              prev;
    logic              prev_vld;

    // Sample chain plus a valid chain so the first post-reset sample never forms an edge.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            pipe     <= '0;
            pipe_vld <= '0;
            prev     <= 1'b0;
            prev_vld <= 1'b0;
        end else begin
            pipe[0]     <= din;
            pipe_vld[0] <= 1'b1;
            for (int unsigned i = 1; i < STAGES; i++) begin
                pipe[i]     <= pipe[i-1];
                pipe_vld[i] <= pipe_vld[i-1];
            end
            prev     <= pipe[STAGES-1];
            prev_vld <= pipe_vld[STAGES-1];
        end
    end

    // Edge flags compare the current sample with the previous one.
    always_comb begin
        lvl  = pipe[STAGES-1];
        rise = prev_vld &  pipe[STAGES-1] & ~prev;
        fall = prev_vld & ~pipe[STAGES-1] &  prev;
    end

endmodule

// File: rtl/cxd_serial_ctrl.sv
// cxd_serial_ctrl: LSB-first serial command receiver with xlat framing,
// status-bit selector and a small command register file.
// Optional build macro: CXD_SERIAL_SYNC_EN (2-flop input synchronizers).
module cxd_serial_ctrl
    import cxd_pkg::*;
#(
    parameter int unsigned CMD_BITS  = CXD_CMD_BITS,
    parameter int unsigned ADDR_BITS = CXD_ADDR_BITS
) (
    input  logic                                 sclk,
    input  logic                                 rst_n,
    input  logic                                 clk,
    input  logic                                 data,
    input  logic                                 xlat,
    input  logic [2**ADDR_BITS-1:0]              sens_data,
    input  logic [ADDR_BITS-1:0]                 rd_addr,
    output logic                                 sens,
    output logic                                 cmd_valid,
    output logic                                 cmd_err,
    output logic [CMD_BITS-1:0]                  cmd_word,
    output logic [cxd_len_width(CMD_BITS)-1:0]   cmd_len,
    output logic [CMD_BITS-1:0]                  rd_data
);

    localparam int unsigned DEPTH = 2**ADDR_BITS;
    localparam int unsigned CNT_W = cxd_cnt_width(CMD_BITS);
    localparam int unsigned LEN_W = cxd_len_width(CMD_BITS);

    logic clk_lvl, clk_rise, clk_fall;
    logic data_lvl, data_rise, data_fall;
    logic xlat_lvl, xlat_rise, xlat_fall;
    logic unused_edges;

    logic [CMD_BITS-1:0]  shift_reg;
    logic [CNT_W-1:0]     bit_cnt;
    logic [ADDR_BITS-1:0] sens_sel;
    logic [CMD_BITS-1:0]  regs [DEPTH];

    logic [CMD_BITS-1:0]  shift_next;
    logic [CNT_W-1:0]     cnt_next;
    logic                 byte_done;
    logic                 frame_ok;

    cxd_edge_sync u_clk_sync (
        .sclk  (sclk),
        .rst_n (rst_n),
        .din   (clk),
        .lvl   (clk_lvl),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    cxd_edge_sync u_data_sync (
        .sclk  (sclk),
        .rst_n (rst_n),
        .din   (data),
        .lvl   (data_lvl),
        .rise  (data_rise),
        .fall  (data_fall)
    );

    cxd_edge_sync u_xlat_sync (
        .sclk  (sclk),
        .rst_n (rst_n),
        .din   (xlat),
        .lvl   (xlat_lvl),
        .rise  (xlat_rise),
        .fall  (xlat_fall)
    );

    assign unused_edges = &{1'b0, clk_lvl, clk_fall, data_rise, data_fall, xlat_lvl, xlat_rise};

    // Next shift/count values and frame-length classification.
    always_comb begin
        shift_next = {data_lvl, shift_reg[CMD_BITS-1:1]};
        cnt_next   = (bit_cnt == CNT_W'(CMD_BITS + 1)) ? bit_cnt : bit_cnt + CNT_W'(1);
        byte_done  = ((cnt_next % CNT_W'(CXD_BYTE_BITS)) == '0) &&
                     (cnt_next <= CNT_W'(CMD_BITS));
        frame_ok   = (bit_cnt != '0) &&
                     ((bit_cnt % CNT_W'(CXD_BYTE_BITS)) == '0) &&
                     (bit_cnt <= CNT_W'(CMD_BITS));
    end

    // Frame assembly, decode, register file and registered outputs.
    // xlat fall takes priority over a coincident clk rise, dropping that bit.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            sens_sel  <= '0;
            sens      <= 1'b0;
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            cmd_word  <= '0;
            cmd_len   <= '0;
            rd_data   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            cmd_valid <= 1'b0;
            cmd_err   <= 1'b0;
            sens      <= sens_data[sens_sel];
            rd_data   <= regs[rd_addr];
            if (xlat_fall) begin
                if (frame_ok) begin
                    cmd_valid <= 1'b1;
                    cmd_word  <= shift_reg;
                    cmd_len   <= LEN_W'(bit_cnt / CNT_W'(CXD_BYTE_BITS));
                    regs[shift_reg[CMD_BITS-1 -: ADDR_BITS]] <= shift_reg;
                end else begin
                    cmd_err <= 1'b1;
                end
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else if (clk_rise) begin
                shift_reg <= shift_next;
                bit_cnt   <= cnt_next;
                if (byte_done) begin
                    sens_sel <= shift_next[CMD_BITS-1 -: ADDR_BITS];
                end
            end
        end
    end

endmodule

// File: tb/tb_cxd_serial_ctrl.sv
// tb_cxd_serial_ctrl: scoreboard bench for cxd_serial_ctrl (default parameters).
module tb_cxd_serial_ctrl;

    typedef struct {
        logic        err;
        logic [23:0] word;
        logic [2:0]  len;
    } exp_t;

    logic        sclk = 1'b0;
    logic        rst_n;
    logic        clk;
    logic        data;
    logic        xlat;
    logic [15:0] sens_data;
    logic [3:0]  rd_addr;
    logic        sens;
    logic        cmd_valid;
    logic        cmd_err;
    logic [23:0] cmd_word;
    logic [2:0]  cmd_len;
    logic [23:0] rd_data;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    exp_t        exp_q[$];

    logic [23:0] m_shift;
    int unsigned m_cnt;
    logic [3:0]  m_sel;
    logic [23:0] m_word;
    logic [2:0]  m_len;
    logic [23:0] m_regs [16];

    cxd_serial_ctrl #(.CMD_BITS(24), .ADDR_BITS(4)) dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .clk       (clk),
        .data      (data),
        .xlat      (xlat),
        .sens_data (sens_data),
        .rd_addr   (rd_addr),
        .sens      (sens),
        .cmd_valid (cmd_valid),
        .cmd_err   (cmd_err),
        .cmd_word  (cmd_word),
        .cmd_len   (cmd_len),
        .rd_data   (rd_data)
    );

    always #5 sclk = ~sclk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int unsigned n);
        repeat (n) @(negedge sclk);
    endtask

    task automatic model_reset();
        m_shift = '0;
        m_cnt   = 0;
        m_sel   = '0;
        m_word  = '0;
        m_len   = '0;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
    endtask

    task automatic check_sens(input string tag);
        sens_data = 16'h1 << m_sel;
        wait_cyc(3);
        check({tag, "_hi"}, 64'(sens), 64'd1);
        sens_data = ~(16'h1 << m_sel);
        wait_cyc(3);
        check({tag, "_lo"}, 64'(sens), 64'd0);
    endtask

    task automatic check_rd(input logic [3:0] addr);
        rd_addr = addr;
        wait_cyc(2);
        check("rd_data", 64'(rd_data), 64'(m_regs[addr]));
    endtask

    task automatic send_bit(input logic b);
        data = b;
        wait_cyc(5);
        clk = 1'b1;
        wait_cyc(5);
        m_shift = {b, m_shift[23:1]};
        if (m_cnt < 25) m_cnt++;
        if ((m_cnt % 8) == 0 && m_cnt <= 24) begin
            m_sel = m_shift[23:20];
            check_sens("sens_byte");
        end
        clk = 1'b0;
    endtask

    task automatic send_bits(input logic [31:0] val, input int unsigned n);
        logic [31:0] v;
        v = val;
        for (int unsigned i = 0; i < n; i++) send_bit(v[i]);
    endtask

    task automatic model_latch();
        exp_t e;
        if (m_cnt != 0 && (m_cnt % 8) == 0 && m_cnt <= 24) begin
            m_word = m_shift;
            m_len  = 3'(m_cnt / 8);
            m_regs[m_shift[23:20]] = m_shift;
            e.err = 1'b0;
        end else begin
            e.err = 1'b1;
        end
        e.word = m_word;
        e.len  = m_len;
        exp_q.push_back(e);
        m_shift = '0;
        m_cnt   = 0;
    endtask

    task automatic latch_frame();
        wait_cyc(5);
        model_latch();
        xlat = 1'b0;
        wait_cyc(5);
        xlat = 1'b1;
        wait_cyc(5);
    endtask

    // Output monitor: every pulse must match the next scoreboard entry.
    always @(negedge sclk) begin
        if (rst_n && (cmd_valid || cmd_err)) begin
            exp_t e;
            check("valid_err_excl", 64'(cmd_valid & cmd_err), 64'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("cmd_err", 64'(cmd_err), 64'(e.err));
                check("cmd_valid", 64'(cmd_valid), 64'(!e.err));
                check("cmd_word", 64'(cmd_word), 64'(e.word));
                check("cmd_len", 64'(cmd_len), 64'(e.len));
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_sens"}, 64'(sens), 64'd0);
        check({tag, "_valid"}, 64'(cmd_valid), 64'd0);
        check({tag, "_err"}, 64'(cmd_err), 64'd0);
        check({tag, "_word"}, 64'(cmd_word), 64'd0);
        check({tag, "_len"}, 64'(cmd_len), 64'd0);
        check({tag, "_rd"}, 64'(rd_data), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        clk       = 1'b0;
        data      = 1'b0;
        xlat      = 1'b1;
        sens_data = 16'hFFFF;
        rd_addr   = 4'd0;
        model_reset();
        wait_cyc(3);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        wait_cyc(5);

        // 8-bit frame 0x8C
        send_bits(32'h8C, 8);
        latch_frame();
        check_sens("sens_8c");
        check_rd(4'd8);

        // 24-bit frame 0x123456: selector 5, 3, 1 checked inside send_bit
        send_bits(32'h123456, 24);
        latch_frame();
        check_sens("sens_24");
        check_rd(4'd1);

        // 5-bit short frame: error, nothing else changes
        send_bits(32'h15, 5);
        latch_frame();
        check_sens("sens_after_short");
        check_rd(4'd8);
        check_rd(4'd1);
        send_bits(32'hA3, 8);
        latch_frame();
        check_rd(4'd10);

        // 25-bit overflow frame: error, cmd_word keeps 0xA30000
        send_bits(32'h1ABCDEF, 25);
        latch_frame();
        check("word_after_overflow", 64'(cmd_word), 64'(m_word));

        // 7 bits, then 8th clk rise coincident with xlat fall
        send_bits(32'h7F, 7);
        data = 1'b1;
        wait_cyc(5);
        model_latch();
        clk  = 1'b1;
        xlat = 1'b0;
        wait_cyc(5);
        xlat = 1'b1;
        clk  = 1'b0;
        wait_cyc(5);
        check_sens("sens_after_coincident");

        // Reset after 12 bits with clk/data held high across release
        send_bits(32'h5A5, 12);
        wait_cyc(2);
        rst_n = 1'b0;
        clk   = 1'b1;
        data  = 1'b1;
        model_reset();
        wait_cyc(3);
        check_zero_outputs("midreset");
        rst_n = 1'b1;
        wait_cyc(6);
        clk = 1'b0;
        wait_cyc(5);
        check_rd(4'd1);
        send_bits(32'h8C, 8);
        latch_frame();
        check("word_after_reset", 64'(cmd_word), 64'h8C0000);
        check_rd(4'd8);

        wait_cyc(10);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
